// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and the lock-state enumeration, reused by the
// sync generator and the sync decoder.
package vga_timing_pkg;

  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } sync_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-register pipeline on one sync input: the second stage is the delayed
// level, and the two stages are compared to form one-clock rise/fall pulses.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic stage1_reg;
  logic stage2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_reg <= 1'b0;
      stage2_reg <= 1'b0;
    end else begin
      stage1_reg <= sync_in;
      stage2_reg <= stage1_reg;
    end
  end

  // Pulses lead the delayed level by one clock, so anything registered from
  // them lines up with level on the following clock.
  assign level = stage2_reg;
  assign rise  = stage1_reg & ~stage2_reg;
  assign fall  = ~stage1_reg & stage2_reg;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers column/row position from an HSync/VSync pair, checks every edge
// against the nominal timing, and reports lock, frame start and errors.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int TOTAL_COLS  = H_TOTAL,
  parameter int TOTAL_ROWS  = V_TOTAL,
  parameter int ACTIVE_COLS = H_ACTIVE,
  parameter int ACTIVE_ROWS = V_ACTIVE,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_HSync,
  input  logic       i_VSync,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start,
  output logic       o_Locked,
  output logic       o_Error
);

  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [9:0] COL_LAST  = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST  = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] HFALL_COL = 10'(ACTIVE_COLS - 1);
  localparam logic [9:0] VFALL_ROW = 10'(ACTIVE_ROWS - 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_FRAMES);

  logic h_level, h_rise, h_fall;
  logic v_level, v_rise, v_fall;

  sync_edge_detect u_hsync_edge (
    .clk    (i_Clk),
    .rst_n  (i_Rst_L),
    .sync_in(i_HSync),
    .level  (h_level),
    .rise   (h_rise),
    .fall   (h_fall)
  );

  sync_edge_detect u_vsync_edge (
    .clk    (i_Clk),
    .rst_n  (i_Rst_L),
    .sync_in(i_VSync),
    .level  (v_level),
    .rise   (v_rise),
    .fall   (v_fall)
  );

  logic [9:0]        col_reg, col_next;
  logic [9:0]        row_reg, row_next;
  logic              col_last, col_wrap;
  logic              line_bad, frame_bad, violation;
  sync_state_e       state_reg, state_next;
  logic [GOOD_W-1:0] good_reg, good_next;
  logic              frame_start_reg, locked_reg, error_reg, error_next;

  assign col_last = (col_reg == COL_LAST);
  assign col_wrap = h_rise | col_last;

  always_comb begin
    col_next = col_last ? 10'd0 : col_reg + 10'd1;
    if (h_rise) col_next = 10'd0;
    row_next = row_reg;
    if (col_wrap) row_next = (row_reg == ROW_LAST) ? 10'd0 : row_reg + 10'd1;
    if (v_rise) row_next = 10'd0;
  end

  // An edge off its nominal position is a violation, and so is a nominal
  // position that passes without its edge.
  assign line_bad  = (h_rise != col_last) | (h_fall != (col_reg == HFALL_COL));
  assign frame_bad = (v_rise != (col_last & (row_reg == ROW_LAST)))
                   | (v_fall != (col_last & (row_reg == VFALL_ROW)));
  assign violation = line_bad | frame_bad;

  always_comb begin
    state_next = state_reg;
    good_next  = good_reg;
    error_next = 1'b0;
    case (state_reg)
      ST_SEARCH: begin
        if (v_rise) begin
          state_next = ST_MEASURE;
          good_next  = '0;
        end
      end
      ST_MEASURE: begin
        if (violation) begin
          state_next = ST_SEARCH;
        end else if (v_rise) begin
          if (good_reg != GOOD_MAX) good_next = good_reg + 1'b1;
          if (good_next == GOOD_MAX) state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (violation) begin
          state_next = ST_SEARCH;
          error_next = 1'b1;
        end
      end
      default: state_next = ST_SEARCH;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg       <= ST_SEARCH;
      good_reg        <= '0;
      col_reg         <= 10'd0;
      row_reg         <= 10'd0;
      frame_start_reg <= 1'b0;
      locked_reg      <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      good_reg        <= good_next;
      col_reg         <= col_next;
      row_reg         <= row_next;
      frame_start_reg <= v_rise;
      locked_reg      <= (state_next == ST_LOCKED);
      error_reg       <= error_next;
    end
  end

  assign o_HSync       = h_level;
  assign o_VSync       = v_level;
  assign o_Col_Count   = col_reg;
  assign o_Row_Count   = row_reg;
  assign o_Frame_Start = frame_start_reg;
  assign o_Locked      = locked_reg;
  assign o_Error       = error_reg;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Drives a scaled-down sync generator with randomly placed timing faults and
// resets, and compares the decoder against an arithmetic timing reference.
module tb_vga_sync_decoder;

  localparam int TC = 40;
  localparam int TR = 12;
  localparam int AC = 32;
  localparam int AR = 9;
  localparam int LF = 2;
  localparam int FRAME = TC * TR;

  localparam int M_SEARCH  = 0;
  localparam int M_MEASURE = 1;
  localparam int M_LOCKED  = 2;

  localparam int F_NONE     = 0;
  localparam int F_DELAY    = 1;
  localparam int F_SUPPRESS = 2;
  localparam int F_SHORTEN  = 3;
  localparam int F_RESET    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       hs_in = 1'b0;
  logic       vs_in = 1'b0;
  logic       hs_out, vs_out, fs_out, lock_out, err_out;
  logic [9:0] col_out, row_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .TOTAL_COLS (TC),
    .TOTAL_ROWS (TR),
    .ACTIVE_COLS(AC),
    .ACTIVE_ROWS(AR),
    .LOCK_FRAMES(LF)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_HSync      (hs_in),
    .i_VSync      (vs_in),
    .o_HSync      (hs_out),
    .o_VSync      (vs_out),
    .o_Col_Count  (col_out),
    .o_Row_Count  (row_out),
    .o_Frame_Start(fs_out),
    .o_Locked     (lock_out),
    .o_Error      (err_out)
  );

  // generator state
  int g_col = 0;
  int g_row = 0;
  int fault_kind = F_NONE;
  int fault_row = -1;
  bit stalled = 1'b0;

  // reference model state
  int m_mode, m_good, m_t = 0, m_t0 = 0;
  bit m_prev_vs, m_prev_hs;

  // expectations for the outputs after the next clock edge
  bit p_hs, p_vs, p_fs, p_lock, p_err, p_cnt, p_origin;
  int p_col, p_row;

  int err_pulses = 0;
  int fs_pulses = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hsync"}, hs_out, 0);
    check({tag, "_vsync"}, vs_out, 0);
    check({tag, "_col"}, col_out, 0);
    check({tag, "_row"}, row_out, 0);
    check({tag, "_fstart"}, fs_out, 0);
    check({tag, "_locked"}, lock_out, 0);
    check({tag, "_error"}, err_out, 0);
  endtask

  task automatic model_reset();
    m_mode = M_SEARCH;
    m_good = 0;
    m_prev_vs = 1'b0;
    m_prev_hs = 1'b0;
    p_hs = 0; p_vs = 0; p_fs = 0; p_lock = 0; p_err = 0;
    p_cnt = 0; p_origin = 0; p_col = 0; p_row = 0;
  endtask

  // Position is the time since the aligning VSync rise, folded into a frame;
  // any input level that disagrees with that nominal timing is a deviation.
  task automatic model_step(input bit h, input bit v);
    bit vrise, hrise, dev, was_locked;
    int pos, rc, rr;
    vrise = v && !m_prev_vs;
    hrise = h && !m_prev_hs;
    was_locked = (m_mode == M_LOCKED);
    dev = 1'b0;
    rc = 0;
    rr = 0;
    if (m_mode != M_SEARCH) begin
      pos = (m_t - m_t0) % FRAME;
      rc = pos % TC;
      rr = pos / TC;
      dev = (h != (rc < AC)) || (v != (rr < AR));
    end
    p_err = 1'b0;
    if (dev) begin
      if (was_locked) p_err = 1'b1;
      m_mode = M_SEARCH;
    end else if (vrise) begin
      if (m_mode == M_SEARCH) begin
        m_mode = M_MEASURE;
        m_good = 0;
        m_t0 = m_t;
      end else if (m_mode == M_MEASURE) begin
        m_good++;
        if (m_good >= LF) m_mode = M_LOCKED;
      end
    end
    p_hs = h;
    p_vs = v;
    p_fs = vrise;
    p_origin = vrise && hrise;
    p_lock = (m_mode == M_LOCKED);
    p_cnt = was_locked || p_lock;
    p_col = rc;
    p_row = rr;
    m_prev_vs = v;
    m_prev_hs = h;
    m_t++;
  endtask

  task automatic tick();
    bit h, v;
    h = (g_col < AC);
    v = (g_row < AR);
    if (fault_kind != F_NONE && g_row == fault_row) begin
      if (fault_kind == F_SUPPRESS) h = 1'b0;
      if (fault_kind == F_SHORTEN) h = (g_col < AC - 1);
    end
    hs_in = h;
    vs_in = v;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      check_all_zero("reset_hold");
      model_reset();
    end else begin
      check("hsync", hs_out, p_hs);
      check("vsync", vs_out, p_vs);
      check("frame_start", fs_out, p_fs);
      check("locked", lock_out, p_lock);
      check("error", err_out, p_err);
      if (p_cnt) begin
        check("col_count", col_out, p_col);
        check("row_count", row_out, p_row);
      end
      if (p_origin) begin
        check("origin_col", col_out, 0);
        check("origin_row", row_out, 0);
      end
      if (err_out) err_pulses++;
      if (fs_out) fs_pulses++;
      model_step(h, v);
    end
    if (fault_kind == F_DELAY && g_row == fault_row && g_col == TC - 1 && !stalled) begin
      stalled = 1'b1;
    end else begin
      if (g_row == fault_row && g_col == TC - 1) fault_kind = F_NONE;
      g_col++;
      if (g_col == TC) begin
        g_col = 0;
        g_row = (g_row + 1) % TR;
      end
    end
  endtask

  task automatic wait_lock(input string tag);
    int n;
    n = 0;
    while (!lock_out && n < 6 * FRAME) begin
      tick();
      n++;
    end
    check(tag, lock_out, 1);
  endtask

  initial begin
    int kind, r, c, n;
    model_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_async");
    repeat (3) tick();
    g_col = 0;
    g_row = 0;
    rst_n = 1'b1;
    fs_pulses = 0;
    wait_lock("initial_lock");
    check("lock_at_third_vrise", fs_pulses, 3);

    for (int ep = 0; ep < 10; ep++) begin
      kind = (ep % 4) + 1;
      repeat ($urandom_range(0, FRAME - 1)) tick();
      n = 0;
      while (!(g_row == 0 && g_col == 0) && n < FRAME + 2) begin
        tick();
        n++;
      end
      err_pulses = 0;
      if (kind == F_RESET) begin
        r = $urandom_range(1, TR - 2);
        c = $urandom_range(0, TC - 1);
        n = 0;
        while (!(g_row == r && g_col == c) && n < FRAME + 2) begin
          tick();
          n++;
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_midframe");
        repeat ($urandom_range(2, 5)) tick();
        rst_n = 1'b1;
        repeat (2 * FRAME) tick();
        check("no_early_relock", lock_out, 0);
        check("reset_error_pulses", err_pulses, 0);
      end else begin
        fault_kind = kind;
        fault_row = $urandom_range(1, TR - 2);
        stalled = 1'b0;
        n = 0;
        while (fault_kind != F_NONE && n < 2 * FRAME) begin
          tick();
          n++;
        end
        repeat (4) tick();
        check("fault_error_pulses", err_pulses, 1);
        check("fault_unlocked", lock_out, 0);
      end
      wait_lock("relock");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter TOTAL_COLS, default 800: clocks per line.
REQ-002 Parameter TOTAL_ROWS, default 525: lines per frame.
REQ-003 Parameter ACTIVE_COLS, default 640: clocks per line with HSync high.
REQ-004 Parameter ACTIVE_ROWS, default 480: lines per frame with VSync high.
REQ-005 Parameter LOCK_FRAMES, default 2: consecutive good frames required to lock.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low. Ports follow.
REQ-007 i_Clk  input  1  pixel clock; all logic on rising edge.
REQ-008 i_Rst_L  input  1  asynchronous active-low reset.
REQ-009 i_HSync  input  1  high during active columns; rising edge marks column 0.
REQ-010 i_VSync  input  1  high during active rows; rising edge marks row 0, column 0.
REQ-011 o_HSync  output  1  i_HSync delayed 2 clocks.
REQ-012 o_VSync  output  1  i_VSync delayed 2 clocks.
REQ-013 o_Col_Count  output  10  recovered column, aligned to o_HSync.
REQ-014 o_Row_Count  output  10  recovered row, aligned to o_VSync.
REQ-015 o_Frame_Start  output  1  one-clock pulse at recovered row 0, column 0.
REQ-016 o_Locked  output  1  high while in LOCKED.
REQ-017 o_Error  output  1  one-clock pulse on timing violation while LOCKED.

Function
REQ-018 Stage 1 SHALL register inputs. Stage 2 SHALL register the stage-1 values and detect edges by comparing stage 1 with stage 2. All outputs SHALL be registered, with total latency exactly 2 clocks from sync input to aligned output.
REQ-019 Column counter: on an HSync rising edge, load 0. Otherwise increment, wrapping TOTAL_COLS-1 -> 0 (freewheel when edges are missing).
REQ-020 Row counter: on a VSync rising edge, load 0. Otherwise increment on each column wrap to 0 (by edge or freewheel), wrapping TOTAL_ROWS-1 -> 0.
REQ-021 Simultaneous HSync and VSync rising edges SHALL yield col=0, row=0 and o_Frame_Start=1 on the same clock.
REQ-022 A line is good only if it meets both conditions:
- the HSync rising edge occurs exactly when the column count would wrap, i.e. previous col = TOTAL_COLS-1;
- the HSync falling edge occurs at col = ACTIVE_COLS.
REQ-023 A frame is good only if it meets all conditions:
- every line is good;
- the VSync rising edge occurs exactly at the row wrap from TOTAL_ROWS-1;
- the VSync falling edge occurs at row = ACTIVE_ROWS, col = 0.
REQ-024 A missing expected edge (counter wraps with no edge) SHALL count as a violation, as SHALL an edge at an unexpected position.
REQ-025 FSM states are SEARCH, MEASURE, LOCKED; reset state is SEARCH.
REQ-026 SEARCH -> MEASURE on a VSync rising edge; the good-frame counter clears.
REQ-027 In MEASURE, any violation -> SEARCH, with no o_Error.
REQ-028 In MEASURE, each good frame increments the good-frame counter. The transition to LOCKED occurs at the VSync rising edge that completes LOCK_FRAMES good frames.
REQ-029 In LOCKED, any violation -> SEARCH with a 1-clock o_Error pulse.
REQ-030 o_Locked SHALL drop on the same clock as o_Error.
REQ-031 The counters SHALL keep tracking in all states; the counts are valid only while o_Locked=1.
REQ-032 Good-frame counter width SHALL be $clog2(LOCK_FRAMES+1), saturating at LOCK_FRAMES.

Reset
REQ-033 On i_Rst_L low, all of the following clear immediately:
- outputs o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Frame_Start, o_Locked, o_Error = 0;
- both pipeline stages = 0, FSM = SEARCH, good-frame counter = 0.
REQ-034 Reset asserted mid-frame SHALL abandon lock. After release, the block SHALL require a fresh VSync rising edge plus LOCK_FRAMES good frames before o_Locked=1.
REQ-035 Reset deassertion SHALL be treated as asynchronous-assert/synchronous-release by the instantiating top level; the block adds no synchronizer.

Structure
REQ-036 Shared package vga_timing_pkg SHALL hold the default timing constants (800/525/640/480) and the FSM state enumeration, for reuse by the sync generator and this decoder.
REQ-037 One sub-module, sync_edge_detect, SHALL be instantiated twice (HSync, VSync). Each instance SHALL provide the delayed level plus 1-clock rise/fall pulses.
REQ-038 Counters, violation checks and FSM SHALL reside in vga_sync_decoder.

Verification
REQ-039 Drive with the team's 800x525 sync generator for 3 frames from reset:
- o_Locked rises at the 3rd VSync rising edge;
- o_Col_Count/o_Row_Count equal the generator counts delayed 2 clocks thereafter.
REQ-040 Locked, then delay one HSync rising edge by 1 clock (line of 801):
- o_Error pulses once;
- o_Locked=0 on that clock; FSM in SEARCH;
- relock after LOCK_FRAMES further good frames.
REQ-041 Locked, then suppress one HSync pulse entirely:
- error at the expected wrap clock;
- o_Col_Count freewheels 799 -> 0 with no glitch.
REQ-042 Locked, then shorten HSync high to 639 clocks:
- the falling edge at col 639 flags a violation;
- o_Error pulse.
REQ-043 Assert i_Rst_L low at row 200, col 300 while locked:
- all outputs read 0 while reset is held;
- after release, o_Locked stays 0 until 2 full good frames follow the next VSync rising edge.
REQ-044 First VSync rising edge after reset:
- o_Frame_Start pulses exactly 2 clocks after the input edge;
- col=0 and row=0 on that same clock.
